// File: rtl/sd_fixed_pkg.sv
// sd_fixed_pkg: shared fixed-point definitions for the sphere-decoder datapath.
//   SD_INT_W / SD_FRAC_W / SD_WIDTH : default Q(INT_W).(FRAC_W) component format
//   SD_SAT_MAX                      : symmetric saturation magnitude 2^(W-1)-1
//   cplx_t                          : packed {re, im} complex sample
//   state_t                         : FSM encoding shared by the iterative blocks
package sd_fixed_pkg;
    localparam int SD_INT_W  = 2;
    localparam int SD_FRAC_W = 15;
    localparam int SD_WIDTH  = SD_INT_W + SD_FRAC_W;
    localparam logic [SD_WIDTH-1:0] SD_SAT_MAX = {1'b0, {(SD_WIDTH-1){1'b1}}};
    typedef struct packed {
        logic signed [SD_WIDTH-1:0] re;
        logic signed [SD_WIDTH-1:0] im;
    } cplx_t;
    typedef enum logic [1:0] {ST_IDLE, ST_MULT, ST_DIV, ST_DONE} state_t;
    function automatic cplx_t cplx_pack(logic signed [SD_WIDTH-1:0] re, logic signed [SD_WIDTH-1:0] im);
        cplx_t c;
        c.re = re;
        c.im = im;
        return c;
    endfunction
endpackage

// File: rtl/serial_udiv.sv
// serial_udiv: unsigned restoring divider, one quotient bit per cycle, MSB first.
//   Computes o_q = floor(i_num * 2^(NBITS-1) / i_den) provided i_num < 2*i_den.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_start        : load i_num/i_den and begin (ignored while busy)
//   o_busy         : iterating
//   o_done         : 1-cycle pulse, o_q valid
//   o_q            : NBITS quotient
module serial_udiv #(
    parameter int NBITS = 16,
    parameter int DW    = 35
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [DW-1:0]    i_num,
    input  logic [DW-1:0]    i_den,
    output logic             o_busy,
    output logic             o_done,
    output logic [NBITS-1:0] o_q
);
    localparam int CW = $clog2(NBITS + 1);
    logic [DW:0]    rem;
    logic [DW-1:0]  den;
    logic [CW-1:0]  cnt;
    logic           take;
    assign take = rem >= {1'b0, den};
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rem    <= '0;
            den    <= '0;
            cnt    <= '0;
            o_q    <= '0;
            o_busy <= 1'b0;
            o_done <= 1'b0;
        end else begin
            o_done <= 1'b0;
            if (i_start && !o_busy) begin
                rem    <= {1'b0, i_num};
                den    <= i_den;
                o_q    <= '0;
                cnt    <= CW'(NBITS);
                o_busy <= 1'b1;
            end else if (o_busy) begin
                // remainder stays below 2*den, so one extra bit of headroom suffices
                rem <= (take ? rem - {1'b0, den} : rem) << 1;
                o_q <= {o_q[NBITS-2:0], take};
                cnt <= cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    o_busy <= 1'b0;
                    o_done <= 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/complex_divide.sv
// complex_divide: iterative fixed-point complex divider q = a*conj(b)/|b|^2, saturated to operand width.
//   Build option: define COMPLEX_DIVIDE_ROUND_EN for round-half-away-from-zero (one extra cycle).
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_valid/o_ready: operand handshake, accepted on i_valid & o_ready
//   i_num, i_den   : dividend / divisor, packed {re, im}
//   o_data         : quotient {re, im}, Q(INT_W).(FRAC_W)
//   o_valid        : 1-cycle result strobe
//   o_sat, o_div0  : saturation flag, zero-divisor flag
module complex_divide
    import sd_fixed_pkg::*;
#(
    parameter int INT_W  = SD_INT_W,
    parameter int FRAC_W = SD_FRAC_W,
    localparam int WIDTH = INT_W + FRAC_W
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [2*WIDTH-1:0] i_num,
    input  logic [2*WIDTH-1:0] i_den,
    output logic [2*WIDTH-1:0] o_data,
    output logic               o_valid,
    output logic               o_sat,
    output logic               o_div0
);
`ifdef COMPLEX_DIVIDE_ROUND_EN
    localparam int NB = WIDTH;
`else
    localparam int NB = WIDTH - 1;
`endif
    localparam int PW = 2 * WIDTH + 1;
    localparam logic [WIDTH-1:0] MAX = {1'b0, {(WIDTH-1){1'b1}}};

    state_t                   state, state_nx;
    logic [2*WIDTH-1:0]       num_q, den_q;
    logic signed [WIDTH-1:0]  ar, ai, br, bi;
    logic signed [PW-1:0]     nr, ni;
    logic [PW-1:0]            mr, mi, dd;
    logic                     neg_re, neg_im, ovf_re, ovf_im, div0;
    logic                     busy_re, busy_im, done_re, done_im;
    logic [NB-1:0]            q_re, q_im;
    logic [WIDTH-1:0]         mag_re, mag_im, res_re, res_im;
    logic                     sat_re, sat_im;

    assign {ar, ai} = num_q;
    assign {br, bi} = den_q;
    assign nr = PW'(ar) * PW'(br) + PW'(ai) * PW'(bi);
    assign ni = PW'(ai) * PW'(br) - PW'(ar) * PW'(bi);
    assign dd = PW'(br) * PW'(br) + PW'(bi) * PW'(bi);
    assign mr = nr[PW-1] ? -nr : nr;
    assign mi = ni[PW-1] ? -ni : ni;

    serial_udiv #(.NBITS(NB), .DW(PW)) u_div_re (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(state == ST_MULT),
        .i_num(mr), .i_den(dd), .o_busy(busy_re), .o_done(done_re), .o_q(q_re)
    );
    serial_udiv #(.NBITS(NB), .DW(PW)) u_div_im (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(state == ST_MULT),
        .i_num(mi), .i_den(dd), .o_busy(busy_im), .o_done(done_im), .o_q(q_im)
    );

    // rounding: the extra LSB is the guard bit, added to the magnitude
`ifdef COMPLEX_DIVIDE_ROUND_EN
    assign mag_re = {1'b0, q_re[NB-1:1]} + WIDTH'(q_re[0]);
    assign mag_im = {1'b0, q_im[NB-1:1]} + WIDTH'(q_im[0]);
`else
    assign mag_re = {1'b0, q_re};
    assign mag_im = {1'b0, q_im};
`endif

    // zero divisor: ovf is always set (|n| >= 0); result follows the dividend sign, 0 for a zero dividend
    assign sat_re = ovf_re || mag_re > MAX;
    assign sat_im = ovf_im || mag_im > MAX;
    assign res_re = div0 ? (ar == '0 ? '0 : ar[WIDTH-1] ? -MAX : MAX)
                  : neg_re ? -(sat_re ? MAX : mag_re) : (sat_re ? MAX : mag_re);
    assign res_im = div0 ? (ai == '0 ? '0 : ai[WIDTH-1] ? -MAX : MAX)
                  : neg_im ? -(sat_im ? MAX : mag_im) : (sat_im ? MAX : mag_im);

    always_comb begin
        state_nx = state;
        o_ready  = state == ST_IDLE && !(busy_re || busy_im);
        o_valid  = state == ST_DONE;
        case (state)
            ST_IDLE: if (i_valid && o_ready) state_nx = ST_MULT;
            ST_MULT: state_nx = ST_DIV;
            ST_DIV:  if (done_re && done_im) state_nx = ST_DONE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= ST_IDLE;
            num_q  <= '0;
            den_q  <= '0;
            neg_re <= 1'b0;
            neg_im <= 1'b0;
            ovf_re <= 1'b0;
            ovf_im <= 1'b0;
            div0   <= 1'b0;
            o_data <= '0;
            o_sat  <= 1'b0;
            o_div0 <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == ST_IDLE && state_nx == ST_MULT) begin
                num_q <= i_num;
                den_q <= i_den;
            end
            if (state == ST_MULT) begin
                neg_re <= nr[PW-1];
                neg_im <= ni[PW-1];
                // quotient magnitude must fit W-1 bits: |n|/den < 2^(INT_W-1)
                ovf_re <= mr >= (dd << (INT_W - 1));
                ovf_im <= mi >= (dd << (INT_W - 1));
                div0   <= dd == '0;
            end
            if (state == ST_DIV && state_nx == ST_DONE) begin
                o_data <= {res_re, res_im};
                o_sat  <= sat_re || sat_im || div0;
                o_div0 <= div0;
            end
        end
    end
endmodule

// File: tb/tb_complex_divide.sv
// tb_complex_divide: directed self-checking bench for complex_divide.
module tb_complex_divide;
    import sd_fixed_pkg::*;
    localparam int W = SD_WIDTH;
`ifdef COMPLEX_DIVIDE_ROUND_EN
    localparam int LAT = W + 2;
    localparam int Q34 = 43691;
`else
    localparam int LAT = W + 1;
    localparam int Q34 = 43690;
`endif

    logic           i_clk = 1'b0;
    logic           i_rst_n = 1'b0;
    logic           i_valid = 1'b0;
    logic [2*W-1:0] i_num = '0;
    logic [2*W-1:0] i_den = '0;
    logic           o_ready, o_valid, o_sat, o_div0;
    logic [2*W-1:0] o_data;
    int             vectors = 0;
    int             errors = 0;

    always #5 i_clk = ~i_clk;

    complex_divide dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_num(i_num), .i_den(i_den), .o_data(o_data), .o_valid(o_valid),
        .o_sat(o_sat), .o_div0(o_div0)
    );

    function automatic logic [2*W-1:0] cx(int re, int im);
        return cplx_pack(W'(re), W'(im));
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!o_valid && lat < 100) begin
            @(posedge i_clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_op(string tag, logic [2*W-1:0] a, logic [2*W-1:0] b,
                          logic [2*W-1:0] exp, logic es, logic ed);
        int lat;
        check({tag, "_ready"}, 64'(o_ready), 64'd1);
        i_num = a;
        i_den = b;
        i_valid = 1'b1;
        @(posedge i_clk);
        #1 i_valid = 1'b0;
        wait_valid(lat);
        check({tag, "_lat"}, 64'(lat), 64'(LAT));
        check({tag, "_data"}, 64'(o_data), 64'(exp));
        check({tag, "_sat"}, 64'(o_sat), 64'(es));
        check({tag, "_div0"}, 64'(o_div0), 64'(ed));
        @(posedge i_clk);
        #1;
        check({tag, "_vpulse"}, 64'(o_valid), 64'd0);
    endtask

    initial begin
        int lat;
        int seen;
        #12;
        check("rst_ready", 64'(o_ready), 64'd1);
        check("rst_valid", 64'(o_valid), 64'd0);
        check("rst_data", 64'(o_data), 64'd0);
        check("rst_flags", 64'({o_sat, o_div0}), 64'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
        run_op("one_by_j", cx(32768, 0), cx(0, 32768), cx(0, -32768), 1'b0, 1'b0);
        run_op("by_one", cx(49152, 16384), cx(32768, 0), cx(49152, 16384), 1'b0, 1'b0);
        run_op("neg_j", cx(-32768, 32768), cx(0, -32768), cx(-32768, -32768), 1'b0, 1'b0);
        run_op("self", cx(16384, 16384), cx(16384, 16384), cx(32768, 0), 1'b0, 1'b0);
        run_op("j_by_1pj", cx(0, 32768), cx(32768, 32768), cx(16384, 16384), 1'b0, 1'b0);
        run_op("sat_pos", cx(32768, 0), cx(8192, 0), cx(65535, 0), 1'b1, 1'b0);
        run_op("sat_neg", cx(-32768, 0), cx(8192, 0), cx(-65535, 0), 1'b1, 1'b0);
        run_op("trunc_pos", cx(32768, 0), cx(24576, 0), cx(Q34, 0), 1'b0, 1'b0);
        run_op("trunc_neg", cx(-32768, 0), cx(24576, 0), cx(-Q34, 0), 1'b0, 1'b0);
        run_op("div0_im", cx(0, 16384), cx(0, 0), cx(0, 65535), 1'b1, 1'b1);
        run_op("div0_re", cx(-16384, 0), cx(0, 0), cx(-65535, 0), 1'b1, 1'b1);

        // i_valid held high while busy: new operands must wait for o_ready
        i_num = cx(49152, 16384);
        i_den = cx(32768, 0);
        i_valid = 1'b1;
        @(posedge i_clk);
        #1;
        i_num = cx(32768, 0);
        i_den = cx(0, 32768);
        check("hold_busy", 64'(o_ready), 64'd0);
        wait_valid(lat);
        check("hold_lat1", 64'(lat), 64'(LAT));
        check("hold_data1", 64'(o_data), 64'(cx(49152, 16384)));
        @(posedge i_clk);
        #1;
        check("hold_ready", 64'(o_ready), 64'd1);
        @(posedge i_clk);
        #1 i_valid = 1'b0;
        check("hold_accept", 64'(o_ready), 64'd0);
        wait_valid(lat);
        check("hold_lat2", 64'(lat), 64'(LAT));
        check("hold_data2", 64'(o_data), 64'(cx(0, -32768)));
        @(posedge i_clk);
        #1;

        // leave saturated flags behind, then reset mid-DIV
        run_op("pre_rst", cx(32768, 0), cx(8192, 0), cx(65535, 0), 1'b1, 1'b0);
        i_num = cx(32768, 0);
        i_den = cx(24576, 0);
        i_valid = 1'b1;
        @(posedge i_clk);
        #1 i_valid = 1'b0;
        repeat (6) @(posedge i_clk);
        #2 i_rst_n = 1'b0;
        #1;
        check("abort_ready", 64'(o_ready), 64'd1);
        check("abort_valid", 64'(o_valid), 64'd0);
        check("abort_data", 64'(o_data), 64'd0);
        check("abort_flags", 64'({o_sat, o_div0}), 64'd0);
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        seen = 0;
        repeat (30) begin
            @(posedge i_clk);
            #1;
            if (o_valid) seen++;
        end
        check("abort_novalid", 64'(seen), 64'd0);
        run_op("post_rst", cx(32768, 0), cx(24576, 0), cx(Q34, 0), 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
